lbm_collide_serializer: RTL and testbench
=========================================

# lbm_collide_serializer

Downstream neighbour of the LBM collider. Captures one cell's nine post-collision distributions (and optionally the macroscopic rho, u_x and u_y) in a single parallel handshake, then emits them as a 16-bit word stream with valid/ready back-pressure toward the streaming/write-back path. Tracks cell position within a frame and marks cell and frame boundaries.

## Interface
Parameters:
- EMIT_MACRO, 1: 1 appends rho, u_x, u_y after the nine distributions (12 words per cell); 0 gives 9 words per cell.
- CELLS_PER_FRAME, 4096: cells per lattice frame. Legal range is 1 to 65536.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  parallel cell data valid.
- in_ready  out  1  block can capture a cell this cycle.
- f_new_null, f_new_n, f_new_ne, f_new_e, f_new_se, f_new_s, f_new_sw, f_new_w, f_new_nw  in  16 each  post-collision distributions, Q3.13.
- rho, u_x, u_y  in  16 each  macroscopic values, Q3.13. Ignored when EMIT_MACRO=0.
- out_data  out  16  current stream word.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts the word.
- out_cell_last  out  1  current word is the final word of a cell.
- out_frame_last  out  1  current word is the final word of the final cell of a frame.
- cell_index  out  16  index of the cell currently held or being sent, 0 to CELLS_PER_FRAME-1.
- frame_done  out  1  one-cycle pulse after the frame's final word handshake.

## Operation
- N = 12 if EMIT_MACRO, else 9.
- Word order: null, n, ne, e, se, s, sw, w, nw, then rho, u_x, u_y. Data is passed bit-exact; no arithmetic is applied.
- Capture handshake: in_valid && in_ready. On capture, all inputs latch into a cell buffer. Upstream values may change afterwards.
- FSM has two states, IDLE and SEND.
  - IDLE: in_ready=1, out_valid=0. A capture moves the FSM to SEND with word_idx=0.
  - SEND: out_valid=1 and out_data=buffer[word_idx].
    - Output handshake (out_valid && out_ready) with word_idx<N-1: word_idx increments.
    - Handshake with word_idx=N-1 while in_valid=1: the next cell is captured in the same cycle; the FSM stays in SEND with word_idx=0.
    - Handshake with word_idx=N-1 while in_valid=0: the FSM goes to IDLE.
- in_ready = (state==IDLE) || (out_valid && out_ready && word_idx==N-1). It is combinational on out_ready. This is the only combinational path through the block.
- out_data, out_valid, out_cell_last, out_frame_last and cell_index come from registers, or from a mux of registers selected by word_idx. None depend combinationally on out_ready.
- out_cell_last = (state==SEND && word_idx==N-1).
- out_frame_last = out_cell_last && cell_index==CELLS_PER_FRAME-1.
- cell_index increments on each cell's final-word handshake and wraps from CELLS_PER_FRAME-1 to 0. With CELLS_PER_FRAME=1 it is always 0 and every cell is frame-last.
- frame_done is registered. It is high for exactly one cycle, the cycle after the out_frame_last handshake.
- While out_valid=1 and out_ready=0, out_data, out_cell_last, out_frame_last and cell_index hold stable (AXI-stream rule).

## Timing
- Reset values: state=IDLE, word_idx=0, cell_index=0, out_valid=0, out_data=0, out_cell_last=0, out_frame_last=0, frame_done=0, buffer=0. in_ready=1 once rst is low.
- Reset mid-cell: the partially sent cell is discarded and cell_index returns to 0. Nothing resumes after reset release.
- Latency: capture at edge k gives out_valid=1 with word 0 during cycle k+1.
- Throughput with out_ready=1 and in_valid=1: one word per cycle, N cycles per cell, no bubbles between cells.
- From IDLE, a cell costs N cycles plus the capture cycle.
- Simultaneous final-word handshake and capture: the new cell's word 0 is presented in the next cycle, and cell_index has already incremented.
- in_valid held high while in_ready=0: nothing is captured and the upstream values are not sampled.

## Test plan
- Reset then single cell: EMIT_MACRO=1, out_ready=1, f_new_null..nw=16'h0E39, 16'h038E, 16'h00E4, 16'h0001..16'h0006, rho=16'h2000, u_x=16'h0010, u_y=16'hFFF0.
  - Required: 12 words in listed order on consecutive cycles starting the cycle after capture.
  - out_cell_last is high only on u_y.
  - in_ready returns to 1 after the last word.
- Back-to-back: in_valid held 1 for 3 cells, out_ready=1, EMIT_MACRO=0.
  - Required: 27 consecutive valid words with no gap.
  - in_ready pulses on cycles 9 and 18 of SEND.
  - cell_index reads 0, 1, 2.
- Back-pressure: toggle out_ready pseudo-randomly on 8 cells.
  - Required: out_data stable while stalled, no word lost or duplicated.
  - Scoreboard matches captured inputs.
- Frame wrap: CELLS_PER_FRAME=4, send 5 cells.
  - Required: out_frame_last only on word N-1 of cell 3.
  - frame_done is high exactly one cycle after it.
  - Fifth cell has cell_index=0.
- Reset mid-cell: assert rst during word 5 of cell 2.
  - Required: out_valid drops asynchronously and cell_index=0.
  - The next cell starts at word 0 (null) with out_frame_last=0.
- Input hold: in_valid=1 while in SEND at word 3, with inputs changing every cycle.
  - Required: the buffer is unchanged and the current cell streams its original values.
  - The new cell is captured only at the word N-1 handshake.

Source files
------------

// File: rtl/lbm_collide_serializer.sv
// lbm_collide_serializer
// Captures one lattice cell's nine post-collision distributions (plus rho,
// u_x, u_y when EMIT_MACRO is set) in a single parallel handshake and replays
// them as a 16-bit valid/ready word stream. Tracks the cell position inside a
// lattice frame and flags cell and frame boundaries on the stream.

module lbm_collide_serializer #(
  parameter int EMIT_MACRO      = 1,
  parameter int CELLS_PER_FRAME = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] f_new_null,
  input  logic [15:0] f_new_n,
  input  logic [15:0] f_new_ne,
  input  logic [15:0] f_new_e,
  input  logic [15:0] f_new_se,
  input  logic [15:0] f_new_s,
  input  logic [15:0] f_new_sw,
  input  logic [15:0] f_new_w,
  input  logic [15:0] f_new_nw,
  input  logic [15:0] rho,
  input  logic [15:0] u_x,
  input  logic [15:0] u_y,
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_cell_last,
  output logic        out_frame_last,
  output logic [15:0] cell_index,
  output logic        frame_done
);

  // Words per cell and the last legal word / cell positions.
  localparam int          N_WORDS   = (EMIT_MACRO != 0) ? 12 : 9;
  localparam logic [3:0]  LAST_WORD = 4'(N_WORDS - 1);
  localparam logic [15:0] LAST_CELL = 16'(CELLS_PER_FRAME - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t      state_r;
  state_t      state_s;
  logic [3:0]  word_idx_r;
  logic [3:0]  word_idx_s;
  logic [15:0] cell_index_r;
  logic [15:0] cell_index_s;
  logic        frame_done_r;
  logic        frame_done_s;
  logic [15:0] buf_r [12];
  logic [15:0] in_word_s [12];
  logic        out_hs_s;
  logic        last_hs_s;
  logic        capture_s;
  logic [15:0] out_data_s;

  // Arrange the parallel inputs in stream order; macro words read as zero when not emitted.
  always_comb begin
    in_word_s[0]  = f_new_null;
    in_word_s[1]  = f_new_n;
    in_word_s[2]  = f_new_ne;
    in_word_s[3]  = f_new_e;
    in_word_s[4]  = f_new_se;
    in_word_s[5]  = f_new_s;
    in_word_s[6]  = f_new_sw;
    in_word_s[7]  = f_new_w;
    in_word_s[8]  = f_new_nw;
    if (EMIT_MACRO != 0) begin
      in_word_s[9]  = rho;
      in_word_s[10] = u_x;
      in_word_s[11] = u_y;
    end else begin
      in_word_s[9]  = 16'h0000;
      in_word_s[10] = 16'h0000;
      in_word_s[11] = 16'h0000;
    end
  end

  // Handshake decode and next-state logic; in_ready is the only path that sees out_ready.
  always_comb begin
    out_hs_s     = (state_r == SEND) && out_ready;
    last_hs_s    = out_hs_s && (word_idx_r == LAST_WORD);
    in_ready     = (state_r == IDLE) || last_hs_s;
    capture_s    = in_valid && in_ready;
    state_s      = state_r;
    word_idx_s   = word_idx_r;
    cell_index_s = cell_index_r;
    frame_done_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (capture_s) begin
          state_s    = SEND;
          word_idx_s = 4'd0;
        end else begin
          state_s    = IDLE;
        end
      end
      SEND: begin
        if (last_hs_s) begin
          // Final word of the cell leaves; a waiting cell is taken in the same edge.
          word_idx_s = 4'd0;
          if (cell_index_r == LAST_CELL) begin
            cell_index_s = 16'd0;
            frame_done_s = 1'b1;
          end else begin
            cell_index_s = cell_index_r + 16'd1;
            frame_done_s = 1'b0;
          end
          if (in_valid) begin
            state_s = SEND;
          end else begin
            state_s = IDLE;
          end
        end else if (out_hs_s) begin
          word_idx_s = word_idx_r + 4'd1;
        end else begin
          word_idx_s = word_idx_r;
        end
      end
      default: begin
        state_s    = IDLE;
        word_idx_s = 4'd0;
      end
    endcase
  end

  // Control state registers: FSM, word pointer, cell counter and frame pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      word_idx_r   <= 4'd0;
      cell_index_r <= 16'd0;
      frame_done_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      word_idx_r   <= word_idx_s;
      cell_index_r <= cell_index_s;
      frame_done_r <= frame_done_s;
    end
  end

  // Cell buffer: loads only on a capture handshake, so upstream may change freely otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 12; i++) begin
        buf_r[i] <= 16'h0000;
      end
    end else if (capture_s) begin
      for (int i = 0; i < 12; i++) begin
        buf_r[i] <= in_word_s[i];
      end
    end else begin
      for (int i = 0; i < 12; i++) begin
        buf_r[i] <= buf_r[i];
      end
    end
  end

  // Output word select: a pure mux of registers addressed by the word pointer.
  always_comb begin
    out_data_s = 16'h0000;
    case (word_idx_r)
      4'd0:    out_data_s = buf_r[0];
      4'd1:    out_data_s = buf_r[1];
      4'd2:    out_data_s = buf_r[2];
      4'd3:    out_data_s = buf_r[3];
      4'd4:    out_data_s = buf_r[4];
      4'd5:    out_data_s = buf_r[5];
      4'd6:    out_data_s = buf_r[6];
      4'd7:    out_data_s = buf_r[7];
      4'd8:    out_data_s = buf_r[8];
      4'd9:    out_data_s = buf_r[9];
      4'd10:   out_data_s = buf_r[10];
      4'd11:   out_data_s = buf_r[11];
      default: out_data_s = 16'h0000;
    endcase
  end

  // Stream outputs derived only from registered state.
  always_comb begin
    out_data       = out_data_s;
    out_valid      = (state_r == SEND);
    out_cell_last  = (state_r == SEND) && (word_idx_r == LAST_WORD);
    out_frame_last = (state_r == SEND) && (word_idx_r == LAST_WORD) &&
                     (cell_index_r == LAST_CELL);
    cell_index     = cell_index_r;
    frame_done     = frame_done_r;
  end

endmodule

// File: tb/tb_lbm_collide_serializer.sv
// Scoreboard bench for lbm_collide_serializer. Instance 0 emits macro words
// with a 4-cell frame; instance 1 emits nine words with a 3-cell frame.
// Stimulus pushes expected words on capture; a monitor pops on handshake.

module tb_lbm_collide_serializer;

  typedef struct packed {
    logic [15:0] data;
    logic        cl;
    logic        fl;
    logic [15:0] idx;
  } exp_t;

  logic clk;
  logic rst;
  logic              in_valid       [2];
  logic              in_ready       [2];
  logic [11:0][15:0] in_w           [2];
  logic [15:0]       out_data       [2];
  logic              out_valid      [2];
  logic              out_ready      [2];
  logic              out_cell_last  [2];
  logic              out_frame_last [2];
  logic [15:0]       cell_index     [2];
  logic              frame_done     [2];

  exp_t qa [$];
  exp_t qb [$];
  int   model_idx  [2];
  bit   fd_exp     [2];
  int   streak     [2];
  int   max_streak [2];
  bit   bp         [2];
  int   total;
  int   bad;

  lbm_collide_serializer #(.EMIT_MACRO(1), .CELLS_PER_FRAME(4)) dut_m (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .f_new_null(in_w[0][0]), .f_new_n(in_w[0][1]), .f_new_ne(in_w[0][2]),
    .f_new_e(in_w[0][3]), .f_new_se(in_w[0][4]), .f_new_s(in_w[0][5]),
    .f_new_sw(in_w[0][6]), .f_new_w(in_w[0][7]), .f_new_nw(in_w[0][8]),
    .rho(in_w[0][9]), .u_x(in_w[0][10]), .u_y(in_w[0][11]),
    .out_data(out_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_cell_last(out_cell_last[0]), .out_frame_last(out_frame_last[0]),
    .cell_index(cell_index[0]), .frame_done(frame_done[0])
  );

  lbm_collide_serializer #(.EMIT_MACRO(0), .CELLS_PER_FRAME(3)) dut_p (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .f_new_null(in_w[1][0]), .f_new_n(in_w[1][1]), .f_new_ne(in_w[1][2]),
    .f_new_e(in_w[1][3]), .f_new_se(in_w[1][4]), .f_new_s(in_w[1][5]),
    .f_new_sw(in_w[1][6]), .f_new_w(in_w[1][7]), .f_new_nw(in_w[1][8]),
    .rho(in_w[1][9]), .u_x(in_w[1][10]), .u_y(in_w[1][11]),
    .out_data(out_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_cell_last(out_cell_last[1]), .out_frame_last(out_frame_last[1]),
    .cell_index(cell_index[1]), .frame_done(frame_done[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int nw(input int k);
    return (k == 0) ? 12 : 9;
  endfunction

  function automatic int cpf(input int k);
    return (k == 0) ? 4 : 3;
  endfunction

  function automatic int q_size(input int k);
    return (k == 0) ? qa.size() : qb.size();
  endfunction

  function automatic exp_t q_front(input int k);
    return (k == 0) ? qa[0] : qb[0];
  endfunction

  task automatic q_pop(input int k);
    if (k == 0) void'(qa.pop_front());
    else void'(qb.pop_front());
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
    end
  endtask

  // Expected stream for one captured cell, built from the inputs present at capture.
  task automatic push_cell(input int k);
    exp_t e;
    for (int i = 0; i < nw(k); i++) begin
      e.data = in_w[k][i];
      e.cl   = (i == nw(k) - 1);
      e.fl   = e.cl && (model_idx[k] == cpf(k) - 1);
      e.idx  = 16'(model_idx[k]);
      if (k == 0) qa.push_back(e);
      else qb.push_back(e);
    end
    model_idx[k] = (model_idx[k] == cpf(k) - 1) ? 0 : model_idx[k] + 1;
  endtask

  // Called at posedge+1; returns at posedge+1 right after the capturing edge.
  task automatic send(input int k, input logic [11:0][15:0] w, input bit churn);
    bit got;
    got = 1'b0;
    in_valid[k] = 1'b1;
    in_w[k] = w;
    for (int t = 0; t < 1000 && !got; t++) begin
      @(negedge clk);
      if (in_ready[k]) begin
        push_cell(k);
        got = 1'b1;
      end
      @(posedge clk);
      #1;
      if (!got && churn) begin
        for (int i = 0; i < 12; i++) in_w[k][i] = 16'($urandom);
      end
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL capture_timeout: inst %0d got no in_ready want in_ready=1", k);
    end
  endtask

  task automatic drain(input int k);
    int t;
    t = 0;
    while (q_size(k) != 0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("drain_queue_empty", 32'(q_size(k)), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    qa.delete();
    qb.delete();
    model_idx[0] = 0;
    model_idx[1] = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  function automatic logic [11:0][15:0] pat(input int c);
    logic [11:0][15:0] w;
    for (int i = 0; i < 12; i++) w[i] = {4'(c), 4'(i), 8'hC3};
    return w;
  endfunction

  function automatic logic [11:0][15:0] t1vec();
    logic [15:0] v [12];
    logic [11:0][15:0] w;
    v = '{16'h0E39, 16'h038E, 16'h00E4, 16'h0001, 16'h0002, 16'h0003,
          16'h0004, 16'h0005, 16'h0006, 16'h2000, 16'h0010, 16'hFFF0};
    for (int i = 0; i < 12; i++) w[i] = v[i];
    return w;
  endfunction

  // Per-instance monitor step: scoreboard compare, in_ready and frame_done models.
  task automatic mon(input int k);
    exp_t e;
    bit   have;
    bit   exp_rdy;
    if (rst) begin
      fd_exp[k] = 1'b0;
      streak[k] = 0;
    end else begin
      have    = (q_size(k) > 0);
      e       = have ? q_front(k) : '0;
      exp_rdy = !out_valid[k] || (out_ready[k] && have && e.cl);
      chk("in_ready", 32'(in_ready[k]), 32'(exp_rdy));
      chk("frame_done", 32'(frame_done[k]), 32'(fd_exp[k]));
      fd_exp[k] = 1'b0;
      if (out_valid[k]) begin
        streak[k]++;
        if (streak[k] > max_streak[k]) max_streak[k] = streak[k];
        if (!have) begin
          total++;
          bad++;
          $display("FAIL unexpected_word: inst %0d got %h want no word", k, out_data[k]);
        end else begin
          chk("out_data", 32'(out_data[k]), 32'(e.data));
          chk("out_cell_last", 32'(out_cell_last[k]), 32'(e.cl));
          chk("out_frame_last", 32'(out_frame_last[k]), 32'(e.fl));
          chk("cell_index", 32'(cell_index[k]), 32'(e.idx));
          if (out_ready[k]) begin
            fd_exp[k] = e.fl;
            q_pop(k);
          end
        end
      end else begin
        streak[k] = 0;
        chk("idle_cell_last", 32'(out_cell_last[k]), 32'd0);
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) mon(k);
    end
  end

  // Consumer ready: constant 1 or pseudo-random when back-pressure is enabled.
  initial begin
    out_ready[0] = 1'b1;
    out_ready[1] = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) out_ready[k] = bp[k] ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    for (int k = 0; k < 2; k++) begin
      in_valid[k] = 1'b0;
      in_w[k] = '0;
      model_idx[k] = 0;
      fd_exp[k] = 1'b0;
      streak[k] = 0;
      max_streak[k] = 0;
      bp[k] = 1'b0;
    end

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("rst_out_valid", 32'(out_valid[k]), 32'd0);
      chk("rst_out_data", 32'(out_data[k]), 32'd0);
      chk("rst_cell_last", 32'(out_cell_last[k]), 32'd0);
      chk("rst_frame_last", 32'(out_frame_last[k]), 32'd0);
      chk("rst_cell_index", 32'(cell_index[k]), 32'd0);
      chk("rst_frame_done", 32'(frame_done[k]), 32'd0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) chk("post_rst_in_ready", 32'(in_ready[k]), 32'd1);
    @(posedge clk);
    #1;

    // Single cell with macros: 12 consecutive words, then idle with in_ready=1.
    send(0, t1vec(), 1'b0);
    in_valid[0] = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("single_valid_run", 32'(out_valid[0]), 32'd1);
    end
    @(negedge clk);
    chk("single_end_valid", 32'(out_valid[0]), 32'd0);
    chk("single_end_in_ready", 32'(in_ready[0]), 32'd1);
    @(posedge clk);
    #1;

    // Back-to-back, nine-word instance: three cells, 27 words without a gap.
    max_streak[1] = 0;
    for (int c = 0; c < 3; c++) send(1, pat(c + 1), 1'b0);
    in_valid[1] = 1'b0;
    drain(1);
    chk("b2b_streak", 32'(max_streak[1]), 32'd27);

    // Frame wrap: five cells in a 4-cell frame.
    do_reset();
    for (int c = 0; c < 5; c++) send(0, pat(c + 4), 1'b0);
    in_valid[0] = 1'b0;
    drain(0);

    // Back-pressure: eight cells with random out_ready and occasional idle gaps.
    bp[0] = 1'b1;
    for (int c = 0; c < 8; c++) begin
      send(0, pat(c + 9), 1'b0);
      if (c % 3 == 2) begin
        in_valid[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
      end
    end
    in_valid[0] = 1'b0;
    drain(0);
    bp[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Input hold: new cell offered with churning data while the previous one streams.
    send(0, pat(2), 1'b0);
    send(0, pat(3), 1'b1);
    in_valid[0] = 1'b0;
    drain(0);

    // Reset mid-cell: during word 5 of the third cell after reset.
    do_reset();
    for (int c = 0; c < 3; c++) send(0, pat(c + 5), 1'b0);
    in_valid[0] = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    chk("pre_rst_word5", 32'(out_data[0]), 32'({4'd7, 4'd5, 8'hC3}));
    rst = 1'b1;
    qa.delete();
    model_idx[0] = 0;
    #1;
    chk("midrst_out_valid", 32'(out_valid[0]), 32'd0);
    chk("midrst_cell_index", 32'(cell_index[0]), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    send(0, pat(12), 1'b0);
    in_valid[0] = 1'b0;
    drain(0);

    chk("final_qa_empty", 32'(qa.size()), 32'd0);
    chk("final_qb_empty", 32'(qb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
